// File: rtl/scan_insertion.sv
// Full-scan version of a two-flop sequential core (qB, qC).
// Every state flop is a mux-D scan cell. The scan chain order is SI -> qB -> qC -> SO.
// TM=1 shifts the chain, and TM=0 captures the functional next state.
// K is the combinational functional output. It is valid in both modes.
// Optional build macro SCAN_LOCKUP_EN: when it is defined, SO comes from a
// falling-edge lockup flop, so it can be stitched into a chain on a skewed clock.
module scan_insertion #(
  parameter logic RST_B = 1'b0,
  parameter logic RST_C = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic A,
  input  logic SI,
  input  logic TM,
  output logic SO,
  output logic K
);

  logic q_b;
  logic q_c;
  logic func_b;
  logic func_c;
  logic d_b;
  logic d_c;

  // Functional next state plus the scan muxes. The mux uses an AND-OR form,
  // so an unknown TM spreads X into both cells instead of being masked.
  always_comb begin
    func_b = A ^ q_c;
    func_c = A & q_b;
    d_b    = (TM & SI)  | (~TM & func_b);
    d_c    = (TM & q_b) | (~TM & func_c);
  end

  // Scan-cell state register. The active-low reset clears the cells at once,
  // regardless of TM and SI.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_b <= RST_B;
      q_c <= RST_C;
    end else begin
      q_b <= d_b;
      q_c <= d_c;
    end
  end

  // Functional observation point. It is high only for {A,qB,qC} = {1,0,1}.
  assign K = A & ~q_b & q_c;

`ifdef SCAN_LOCKUP_EN
  logic so_lockup;

  // Lockup latch stage on the falling clock. SO trails qC by half a cycle.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      so_lockup <= RST_C;
    end else begin
      so_lockup <= q_c;
    end
  end

  assign SO = so_lockup;
`else
  assign SO = q_c;
`endif

endmodule

// File: tb/tb_scan_insertion.sv
// Directed self-checking bench for scan_insertion.
// It covers reset, pattern load, capture, unload, K decoding and reset during shift.
// If SCAN_LOCKUP_EN is defined, SO is also checked for its half-cycle lag.
module tb_scan_insertion;

  logic clk;
  logic reset;
  logic A;
  logic SI;
  logic TM;
  logic SO;
  logic K;

  int pass_count;
  int check_count;

  scan_insertion #(.RST_B(1'b0), .RST_C(1'b0)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .SI   (SI),
    .TM   (TM),
    .SO   (SO),
    .K    (K)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 ns later.
  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  // With the lockup flop present, SO only settles after the falling edge.
  task automatic settle_so();
`ifdef SCAN_LOCKUP_EN
    @(negedge clk);
    #1;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; TM = 1'b1; SI = 1'b1; A = 1'b1;
    #1 reset = 1'b0;
    #1;
    check_count++;
    if (dut.q_b !== 1'b0) $display("[TB] FAIL reset_qb_now: got %b, expected 0", dut.q_b); else pass_count++;
    check_count++;
    if (dut.q_c !== 1'b0) $display("[TB] FAIL reset_qc_now: got %b, expected 0", dut.q_c); else pass_count++;
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL reset_so_now: got %b, expected 0", SO); else pass_count++;
    check_count++;
    if (K !== 1'b0) $display("[TB] FAIL reset_k_now: got %b, expected 0", K); else pass_count++;
    for (int i = 0; i < 3; i++) begin
      clock_edge();
      check_count++;
      if (dut.q_b !== 1'b0) $display("[TB] FAIL reset_held_qb[%0d]: got %b, expected 0", i, dut.q_b); else pass_count++;
      check_count++;
      if (SO !== 1'b0) $display("[TB] FAIL reset_held_so[%0d]: got %b, expected 0", i, SO); else pass_count++;
    end
  endtask

  task automatic test_pattern_load();
    reset = 1'b1; A = 1'b1; TM = 1'b1; SI = 1'b1;
    clock_edge();
    settle_so();
    check_count++;
    if (dut.q_b !== 1'b1) $display("[TB] FAIL load1_qb: got %b, expected 1", dut.q_b); else pass_count++;
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL load1_so: got %b, expected 0", SO); else pass_count++;
    SI = 1'b0;
    clock_edge();
    settle_so();
    check_count++;
    if (dut.q_b !== 1'b0) $display("[TB] FAIL load2_qb: got %b, expected 0", dut.q_b); else pass_count++;
    check_count++;
    if (SO !== 1'b1) $display("[TB] FAIL load2_so: got %b, expected 1", SO); else pass_count++;
    check_count++;
    if (K !== 1'b1) $display("[TB] FAIL load2_k: got %b, expected 1", K); else pass_count++;
  endtask

  task automatic test_k_decode();
    // Start state {qB,qC} = {0,1}. Only A changes, and there is no clock.
    A = 1'b0;
    #1;
    check_count++;
    if (K !== 1'b0) $display("[TB] FAIL k_a0_b0_c1: got %b, expected 0", K); else pass_count++;
    A = 1'b1;
    #1;
    check_count++;
    if (K !== 1'b1) $display("[TB] FAIL k_a1_b0_c1: got %b, expected 1", K); else pass_count++;
  endtask

  task automatic test_capture();
    // Capture 1: {A,qB,qC} = {1,0,1} gives qB = 1^1 = 0 and qC = 1&0 = 0.
    TM = 1'b0; A = 1'b1;
    clock_edge();
    settle_so();
    check_count++;
    if (dut.q_b !== 1'b0) $display("[TB] FAIL cap1_qb: got %b, expected 0", dut.q_b); else pass_count++;
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL cap1_so: got %b, expected 0", SO); else pass_count++;
    check_count++;
    if (K !== 1'b0) $display("[TB] FAIL cap1_k: got %b, expected 0", K); else pass_count++;
    // Capture 2: {1,0,0} gives qB = 1 and qC = 0.
    clock_edge();
    settle_so();
    check_count++;
    if (dut.q_b !== 1'b1) $display("[TB] FAIL cap2_qb: got %b, expected 1", dut.q_b); else pass_count++;
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL cap2_so: got %b, expected 0", SO); else pass_count++;
    // Capture 3: {1,1,0} gives qB = 1 and qC = 1&1 = 1. K is then 1&0&1 = 0.
    clock_edge();
    settle_so();
    check_count++;
    if (dut.q_b !== 1'b1) $display("[TB] FAIL cap3_qb: got %b, expected 1", dut.q_b); else pass_count++;
    check_count++;
    if (SO !== 1'b1) $display("[TB] FAIL cap3_so: got %b, expected 1", SO); else pass_count++;
    check_count++;
    if (K !== 1'b0) $display("[TB] FAIL cap3_k: got %b, expected 0", K); else pass_count++;
    // Capture 4: {0,1,1} gives qB = 0^1 = 1 and qC = 0&1 = 0.
    A = 1'b0;
    clock_edge();
    settle_so();
    check_count++;
    if (dut.q_b !== 1'b1) $display("[TB] FAIL cap4_qb: got %b, expected 1", dut.q_b); else pass_count++;
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL cap4_so: got %b, expected 0", SO); else pass_count++;
  endtask

  task automatic test_unload();
    // The state is {qB,qC} = {1,0}. SO should read 0, then 1, then 0.
    TM = 1'b1; SI = 1'b0;
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL unload0_so: got %b, expected 0", SO); else pass_count++;
    clock_edge();
    settle_so();
    check_count++;
    if (SO !== 1'b1) $display("[TB] FAIL unload1_so: got %b, expected 1", SO); else pass_count++;
    clock_edge();
    settle_so();
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL unload2_so: got %b, expected 0", SO); else pass_count++;
  endtask

  task automatic test_reset_mid_shift();
    TM = 1'b1; SI = 1'b1; A = 1'b0;
    clock_edge();
    clock_edge();
    settle_so();
    check_count++;
    if (SO !== 1'b1) $display("[TB] FAIL midshift_pre_so: got %b, expected 1", SO); else pass_count++;
    #1 reset = 1'b0;
    #1;
    check_count++;
    if (dut.q_b !== 1'b0) $display("[TB] FAIL midshift_qb: got %b, expected 0", dut.q_b); else pass_count++;
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL midshift_so: got %b, expected 0", SO); else pass_count++;
    #1 reset = 1'b1;
    SI = 1'b0;
    clock_edge();
    settle_so();
    check_count++;
    if (dut.q_b !== 1'b0 || SO !== 1'b0) $display("[TB] FAIL after_rst_shift1: got qb=%b so=%b, expected qb=0 so=0", dut.q_b, SO); else pass_count++;
    SI = 1'b1;
    clock_edge();
    SI = 1'b0;
    clock_edge();
    settle_so();
    check_count++;
    if (dut.q_b !== 1'b0 || SO !== 1'b1) $display("[TB] FAIL after_rst_shift3: got qb=%b so=%b, expected qb=0 so=1", dut.q_b, SO); else pass_count++;
  endtask

`ifdef SCAN_LOCKUP_EN
  task automatic test_lockup();
    reset = 1'b0;
    #1 reset = 1'b1;
    TM = 1'b1; A = 1'b1; SI = 1'b1;
    clock_edge();
    SI = 1'b0;
    clock_edge();
    // qC rose at this edge. SO must still be 0 until the falling edge.
    check_count++;
    if (SO !== 1'b0) $display("[TB] FAIL lockup_so_before_negedge: got %b, expected 0", SO); else pass_count++;
    check_count++;
    if (K !== 1'b1) $display("[TB] FAIL lockup_k_posedge: got %b, expected 1", K); else pass_count++;
    @(negedge clk);
    #1;
    check_count++;
    if (SO !== 1'b1) $display("[TB] FAIL lockup_so_after_negedge: got %b, expected 1", SO); else pass_count++;
  endtask
`endif

  initial begin
    pass_count  = 0;
    check_count = 0;
    reset = 1'b1; A = 1'b0; SI = 1'b0; TM = 1'b0;
    test_reset();
    test_pattern_load();
    test_k_decode();
    test_capture();
    test_unload();
    test_reset_mid_shift();
`ifdef SCAN_LOCKUP_EN
    test_lockup();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
